snake_game_ctrl: RTL

Top-level sequencer for the snake datapath. It owns the game-state FSM (INITIAL/RUNNING/PAUSED/DIE), filters button presses into a legal next_direction, and places food on a free cell by LFSR proposal plus a serial scan of the snake body. It also keeps the score. It drives game_state, next_direction, pause and food_x/food_y into the snake block and consumes that block's hit/get_food flags.

---
 rtl/snake_pkg.sv | 46 ++++
 rtl/snake_food_placer.sv | 123 ++++++++++++
 rtl/snake_game_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared state/direction codes, playfield constants and small helpers for the
// snake game control slice.
package snake_pkg;

    localparam int unsigned GRID_W  = 32;
    localparam int unsigned GRID_H  = 24;
    localparam int unsigned MAX_LEN = 64;

    typedef enum logic [1:0] {
        ST_RUNNING = 2'b00,
        ST_DIE     = 2'b01,
        ST_INITIAL = 2'b10,
        ST_PAUSED  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_RIGHT = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        PL_IDLE    = 2'b00,
        PL_PROPOSE = 2'b01,
        PL_SCAN    = 2'b10
    } placer_state_e;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Opposite pairs differ only in bit 0: UP/DOWN and RIGHT/LEFT.
    function automatic dir_e opposite_dir(input dir_e d);
        return dir_e'(d ^ 2'b01);
    endfunction

    // Folds an out-of-range 5-bit coordinate back into 0..lim-1 (lim >= 16).
    function automatic logic [4:0] fold_coord(input logic [4:0] v, input int unsigned lim);
        logic [4:0] span;
        span = 5'(32 - lim);
        return (32'(v) >= lim) ? v - span : v;
    endfunction

endpackage

// File: rtl/snake_food_placer.sv
// Food placer: proposes a cell from a free-running LFSR and accepts it once a
// serial scan of the snake body (one segment per cycle) finds no overlap.
module snake_food_placer
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W    = snake_pkg::GRID_W,
    parameter int unsigned GRID_H    = snake_pkg::GRID_H,
    parameter int unsigned MAX_LEN   = snake_pkg::MAX_LEN,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 clear,
    input  logic [5*MAX_LEN-1:0] snake_x_1dim,
    input  logic [5*MAX_LEN-1:0] snake_y_1dim,
    input  logic [5:0]           snake_length,
    output logic                 busy,
    output logic [4:0]           food_x,
    output logic [4:0]           food_y,
    output logic                 food_valid
);

    placer_state_e state_q, state_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [4:0]    cand_x_q, cand_x_d;
    logic [4:0]    cand_y_q, cand_y_d;
    logic [5:0]    idx_q, idx_d;
    logic [5:0]    len_q, len_d;
    logic [4:0]    food_x_q, food_x_d;
    logic [4:0]    food_y_q, food_y_d;
    logic          food_valid_q, food_valid_d;

    logic [8:0]    seg_base;
    logic [4:0]    seg_x, seg_y;
    logic          seg_hit, last_seg;

    assign seg_base = 9'(idx_q) * 9'd5;
    assign seg_x    = snake_x_1dim[seg_base +: 5];
    assign seg_y    = snake_y_1dim[seg_base +: 5];
    assign seg_hit  = (seg_x == cand_x_q) && (seg_y == cand_y_q);
    // A zero length still scans segment 0; the slot limit guards a bad length.
    assign last_seg = ((idx_q + 6'd1) >= len_q) || (idx_q == 6'(MAX_LEN - 1));

    always_comb begin
        // NOTE: every _d takes its hold value first, so no path through this block leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        lfsr_d       = lfsr_next(lfsr_q);
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        idx_d        = idx_q;
        len_d        = len_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;

        if (abort) begin
            state_d = PL_IDLE;
        end else if (start) begin
            state_d      = PL_PROPOSE;
            food_valid_d = 1'b0;
        end else begin
            case (state_q)
                PL_PROPOSE: begin
                    cand_x_d = fold_coord(lfsr_q[4:0], GRID_W);
                    cand_y_d = fold_coord(lfsr_q[9:5], GRID_H);
                    idx_d    = '0;
                    len_d    = snake_length;
                    state_d  = PL_SCAN;
                end
                PL_SCAN: begin
                    if (seg_hit) begin
                        state_d = PL_PROPOSE;
                    end else if (last_seg) begin
                        food_x_d     = cand_x_q;
                        food_y_d     = cand_y_q;
                        food_valid_d = 1'b1;
                        state_d      = PL_IDLE;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
                default: ;
            endcase
        end

        if (clear) begin
            food_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PL_IDLE;
            lfsr_q       <= LFSR_SEED;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            idx_q        <= '0;
            len_q        <= '0;
            food_x_q     <= '0;
            food_y_q     <= '0;
            food_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
        end
    end

    assign busy       = (state_q != PL_IDLE);
    assign food_x     = food_x_q;
    assign food_y     = food_y_q;
    assign food_valid = food_valid_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: game-state FSM, direction filter, score counter and
// get_food edge detect; food placement is delegated to snake_food_placer.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W    = snake_pkg::GRID_W,
    parameter int unsigned GRID_H    = snake_pkg::GRID_H,
    parameter int unsigned MAX_LEN   = snake_pkg::MAX_LEN,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn_start,
    input  logic                 btn_pause,
    input  logic                 btn_up,
    input  logic                 btn_down,
    input  logic                 btn_right,
    input  logic                 btn_left,
    input  logic [1:0]           current_direction,
    input  logic [5*MAX_LEN-1:0] snake_x_1dim,
    input  logic [5*MAX_LEN-1:0] snake_y_1dim,
    input  logic [5:0]           snake_length,
    input  logic                 hit_boundary,
    input  logic                 hit_self,
    input  logic                 get_food,
    output logic [1:0]           game_state,
    output logic                 pause,
    output logic [1:0]           next_direction,
    output logic [4:0]           food_x,
    output logic [4:0]           food_y,
    output logic                 food_valid,
    output logic [7:0]           score
);

    state_e     state_q, state_d;
    dir_e       next_dir_q, next_dir_d;
    logic       pause_q, pause_d;
    logic [7:0] score_q, score_d;
    logic       get_food_q, get_food_d;

    logic       food_rise;
    dir_e       req_dir;
    logic       req_valid;
    logic       plc_start, plc_abort, plc_clear, plc_busy;

    assign get_food_d = get_food;
    assign food_rise  = get_food & ~get_food_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INITIAL: if (btn_start) state_d = ST_RUNNING;
            ST_RUNNING: begin
                // A collision wins over a same-cycle pause request.
                if (hit_boundary || hit_self) state_d = ST_DIE;
                else if (btn_pause)           state_d = ST_PAUSED;
            end
            ST_PAUSED:  if (btn_pause) state_d = ST_RUNNING;
            ST_DIE:     if (btn_start) state_d = ST_INITIAL;
            default:    state_d = ST_INITIAL;
        endcase
    end

    always_comb begin
        req_valid = 1'b1;
        req_dir   = DIR_UP;
        if (btn_up)         req_dir = DIR_UP;
        else if (btn_down)  req_dir = DIR_DOWN;
        else if (btn_right) req_dir = DIR_RIGHT;
        else if (btn_left)  req_dir = DIR_LEFT;
        else                req_valid = 1'b0;
    end

    always_comb begin
        next_dir_d = next_dir_q;
        if (state_d == ST_INITIAL) begin
            next_dir_d = DIR_UP;
        end else if (state_q == ST_RUNNING && req_valid &&
                     req_dir != opposite_dir(dir_e'(current_direction))) begin
            next_dir_d = req_dir;
        end
    end

    always_comb begin
        score_d = score_q;
        if (state_d == ST_INITIAL) begin
            score_d = '0;
        end else if (state_q == ST_RUNNING && food_rise && score_q != 8'hFF) begin
            score_d = score_q + 8'd1;
        end
    end

    assign pause_d = (state_d == ST_PAUSED);

    assign plc_start = (state_q == ST_INITIAL && state_d == ST_RUNNING) ||
                       (state_q == ST_RUNNING && food_rise);
    assign plc_abort = plc_busy && (state_d != state_q) &&
                       (state_d == ST_DIE || state_d == ST_INITIAL);
    assign plc_clear = (state_d == ST_INITIAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INITIAL;
            next_dir_q <= DIR_UP;
            pause_q    <= 1'b0;
            score_q    <= '0;
            get_food_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            next_dir_q <= next_dir_d;
            pause_q    <= pause_d;
            score_q    <= score_d;
            get_food_q <= get_food_d;
        end
    end

    snake_food_placer #(
        .GRID_W    (GRID_W),
        .GRID_H    (GRID_H),
        .MAX_LEN   (MAX_LEN),
        .LFSR_SEED (LFSR_SEED)
    ) u_placer (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (plc_start),
        .abort        (plc_abort),
        .clear        (plc_clear),
        .snake_x_1dim (snake_x_1dim),
        .snake_y_1dim (snake_y_1dim),
        .snake_length (snake_length),
        .busy         (plc_busy),
        .food_x       (food_x),
        .food_y       (food_y),
        .food_valid   (food_valid)
    );

    assign game_state     = state_q;
    assign pause          = pause_q;
    assign next_direction = next_dir_q;
    assign score          = score_q;

endmodule
